// File: rtl/ifft16_tx.sv
// ifft16_tx: 16-point radix-2 DIT inverse FFT for the OFDM transmit chain.
// A single time-shared butterfly runs 4 stages x 8 butterflies in place on a bit-reversed frame.
module ifft16_tx #(
   parameter int DATA_WIDTH        = 16,
   parameter int DOUBLE_DATA_WIDTH = 32,
   parameter int INT_WIDTH         = 4,
   parameter int FRAC_WIDTH        = 12
) (
   input  logic                                i_clk_ifft16,
   input  logic                                i_rst_n,
   input  logic                                i_valid_ifft16,
   input  logic [15:0][DOUBLE_DATA_WIDTH-1:0]  i_ifft16,
   output logic [15:0][DOUBLE_DATA_WIDTH-1:0]  o_ifft16,
   output logic                                o_done_ifft16,
   output logic                                o_busy_ifft16
);
   localparam int QW = INT_WIDTH + FRAC_WIDTH;
   localparam logic signed [DATA_WIDTH+2:0] SMAX = (1 <<< (DATA_WIDTH-1)) - 1;
   localparam logic signed [DATA_WIDTH+2:0] SMIN = -(1 <<< (DATA_WIDTH-1));
   localparam logic signed [QW-1:0] COS [8] = '{16'sd4096, 16'sd3784, 16'sd2896, 16'sd1567,
                                               16'sd0, -16'sd1567, -16'sd2896, -16'sd3784};
   localparam logic signed [QW-1:0] SIN [8] = '{16'sd0, 16'sd1567, 16'sd2896, 16'sd3784,
                                               16'sd4096, 16'sd3784, 16'sd2896, 16'sd1567};

   typedef enum logic [1:0] {IDLE, BFLY, DONE} state_t;
   state_t state, nxt;

   logic [15:0][DOUBLE_DATA_WIDTH-1:0] mem;
   logic [4:0] cnt;
   logic [1:0] s;
   logic [3:0] span, grp, pos, ia, ib;
   logic [2:0] k;
   logic signed [DATA_WIDTH-1:0] ar, ai, br, bi, wr, wi;
   logic signed [2*DATA_WIDTH:0] pr, pi;
   logic signed [DATA_WIDTH+1:0] tr, ti;
   logic signed [DATA_WIDTH+2:0] sar, sai, sbr, sbi;
   logic signed [DATA_WIDTH-1:0] oar, oai, obr, obi;

   function automatic logic [3:0] rev4(input logic [3:0] v);
      rev4 = {v[0], v[1], v[2], v[3]};
   endfunction

   function automatic logic signed [DATA_WIDTH-1:0] sat(input logic signed [DATA_WIDTH+2:0] v);
      sat = (v > SMAX) ? SMAX[DATA_WIDTH-1:0] : (v < SMIN) ? SMIN[DATA_WIDTH-1:0] : v[DATA_WIDTH-1:0];
   endfunction

   always_comb begin
      s    = cnt[4:3];
      span = 4'd1 << s;
      grp  = {1'b0, cnt[2:0]} >> s;
      pos  = {1'b0, cnt[2:0]} & (span - 4'd1);
      ia   = ((grp << 1) << s) | pos;
      ib   = ia + span;
      k    = 3'(pos << (2'd3 - s));
      ar   = mem[ia][31:16];
      ai   = mem[ia][15:0];
      br   = mem[ib][31:16];
      bi   = mem[ib][15:0];
      wr   = COS[k];
      wi   = SIN[k];
      pr   = wr * br - wi * bi;
      pi   = wr * bi + wi * br;
      tr   = (DATA_WIDTH+2)'(pr >>> FRAC_WIDTH);
      ti   = (DATA_WIDTH+2)'(pi >>> FRAC_WIDTH);
      sar  = ar + tr;
      sai  = ai + ti;
      sbr  = ar - tr;
      sbi  = ai - ti;
      oar  = sat(sar >>> 1);
      oai  = sat(sai >>> 1);
      obr  = sat(sbr >>> 1);
      obi  = sat(sbi >>> 1);
   end

   always_comb begin
      nxt = state;
      nxt = (state == IDLE && i_valid_ifft16) ? BFLY :
            (state == BFLY && cnt == 5'd31)   ? DONE :
            (state == DONE)                   ? IDLE : state;
   end

   always_ff @(posedge i_clk_ifft16 or negedge i_rst_n)
      if (!i_rst_n) state <= IDLE;
      else state <= nxt;

   // Strobes outside IDLE fall through every branch, so they leave no trace.
   always_ff @(posedge i_clk_ifft16 or negedge i_rst_n) begin
      if (!i_rst_n) begin
         mem           <= '0;
         o_ifft16      <= '0;
         o_done_ifft16 <= 1'b0;
         o_busy_ifft16 <= 1'b0;
         cnt           <= '0;
      end else begin
         o_done_ifft16 <= 1'b0;
         if (state == IDLE && i_valid_ifft16) begin
            for (int n = 0; n < 16; n++) mem[rev4(4'(n))] <= i_ifft16[n];
            o_busy_ifft16 <= 1'b1;
            cnt           <= '0;
         end
         if (state == BFLY) begin
            mem[ia] <= {oar, oai};
            mem[ib] <= {obr, obi};
            cnt     <= cnt + 5'd1;
         end
         if (state == DONE) begin
            o_ifft16      <= mem;
            o_done_ifft16 <= 1'b1;
            o_busy_ifft16 <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_ifft16_tx.sv
// tb_ifft16_tx: directed checks of ifft16_tx latency, scaling, rotation direction,
// busy drop, mid-frame reset and full-scale behaviour.
module tb_ifft16_tx;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic valid = 1'b0;
   logic [15:0][31:0] din = '0;
   logic [15:0][31:0] dout;
   logic done, busy;
   int tests = 0;
   int fails = 0;

   ifft16_tx dut (
      .i_clk_ifft16(clk), .i_rst_n(rst_n), .i_valid_ifft16(valid), .i_ifft16(din),
      .o_ifft16(dout), .o_done_ifft16(done), .o_busy_ifft16(busy)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0][31:0] impulse();
      impulse = '0;
      impulse[0] = {16'sd4096, 16'sd0};
   endfunction

   function automatic logic [15:0][31:0] fill(input logic [31:0] v);
      for (int n = 0; n < 16; n++) fill[n] = v;
   endfunction

   function automatic logic [15:0][31:0] tone();
      tone = '0;
      tone[1] = {16'sd4096, 16'sd0};
   endfunction

   function automatic int re(input int n);
      logic signed [15:0] v;
      v = dout[n][31:16];
      re = v;
   endfunction

   function automatic int im(input int n);
      logic signed [15:0] v;
      v = dout[n][15:0];
      im = v;
   endfunction

   function automatic bit near(input int a, input int e);
      near = (a - e <= 2) && (e - a <= 2);
   endfunction

   task automatic run_frame(input logic [15:0][31:0] d, output int lat, output int ndone);
      @(negedge clk);
      din = d;
      valid = 1'b1;
      @(posedge clk);
      #1 valid = 1'b0;
      lat = 0;
      ndone = 0;
      for (int c = 1; c <= 40; c++) begin
         @(posedge clk);
         #1;
         if (done) begin
            ndone++;
            if (lat == 0) lat = c;
         end
      end
   endtask

   task automatic test_reset();
      #1;
      tests++; if (dout !== '0) begin fails++; $display("FAIL reset_out got %h want 0", dout); end
      tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done got %b want 0", done); end
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
      repeat (3) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
   endtask

   task automatic test_impulse();
      int lat, nd;
      run_frame(impulse(), lat, nd);
      tests++; if (lat !== 33) begin fails++; $display("FAIL impulse_latency got %0d want 33", lat); end
      tests++; if (nd !== 1) begin fails++; $display("FAIL impulse_done_width got %0d want 1", nd); end
      for (int n = 0; n < 16; n++) begin
         tests++;
         if (re(n) !== 256 || im(n) !== 0) begin
            fails++; $display("FAIL impulse_x%0d got (%0d,%0d) want (256,0)", n, re(n), im(n));
         end
      end
   endtask

   task automatic test_constant();
      int lat, nd;
      run_frame(fill({16'sd4096, 16'sd0}), lat, nd);
      for (int n = 0; n < 16; n++) begin
         tests++;
         if (!near(re(n), n == 0 ? 4096 : 0) || !near(im(n), 0)) begin
            fails++; $display("FAIL constant_x%0d got (%0d,%0d) want (%0d,0)", n, re(n), im(n), n == 0 ? 4096 : 0);
         end
      end
   endtask

   task automatic test_tone();
      int lat, nd;
      int idx [5] = '{0, 2, 4, 8, 12};
      int er [5] = '{256, 181, 0, -256, 0};
      int ei [5] = '{0, 181, 256, 0, -256};
      run_frame(tone(), lat, nd);
      for (int i = 0; i < 5; i++) begin
         tests++;
         if (!near(re(idx[i]), er[i]) || !near(im(idx[i]), ei[i])) begin
            fails++; $display("FAIL tone_x%0d got (%0d,%0d) want (%0d,%0d)", idx[i], re(idx[i]), im(idx[i]), er[i], ei[i]);
         end
      end
   endtask

   task automatic test_back_to_back();
      int d1, d2, nd;
      d1 = 0; d2 = 0; nd = 0;
      @(negedge clk);
      din = impulse();
      valid = 1'b1;
      @(posedge clk);
      #1 valid = 1'b0;
      tests++; if (busy !== 1'b1) begin fails++; $display("FAIL busy_high got %b want 1", busy); end
      for (int c = 1; c <= 75; c++) begin
         @(posedge clk);
         #1 valid = 1'b0;
         if (done) begin
            nd++;
            if (d1 == 0) d1 = c; else if (d2 == 0) d2 = c;
         end
         if (c == 33) begin
            tests++;
            if (re(5) !== 256 || im(13) !== 0 || re(13) !== 256) begin
               fails++; $display("FAIL busy_first_frame got x5=%0d x13=(%0d,%0d) want 256 (256,0)", re(5), re(13), im(13));
            end
         end
         if (c == 67) begin
            tests++;
            if (!near(re(0), 4096) || !near(re(7), 0)) begin
               fails++; $display("FAIL busy_second_frame got x0=%0d x7=%0d want 4096 0", re(0), re(7));
            end
         end
         if (c == 4) begin din = tone(); valid = 1'b1; end
         if (c == 33) begin din = fill({16'sd4096, 16'sd0}); valid = 1'b1; end
      end
      tests++; if (d1 !== 33) begin fails++; $display("FAIL busy_done1 got %0d want 33", d1); end
      tests++; if (d2 !== 67) begin fails++; $display("FAIL busy_done2 got %0d want 67", d2); end
      tests++; if (nd !== 2) begin fails++; $display("FAIL busy_done_count got %0d want 2", nd); end
   endtask

   task automatic test_reset_mid();
      int lat, nd;
      nd = 0;
      @(negedge clk);
      din = tone();
      valid = 1'b1;
      @(posedge clk);
      #1 valid = 1'b0;
      repeat (9) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      tests++; if (dout !== '0) begin fails++; $display("FAIL midreset_out got %h want 0", dout); end
      tests++; if (busy !== 1'b0 || done !== 1'b0) begin fails++; $display("FAIL midreset_flags got busy=%b done=%b want 0 0", busy, done); end
      repeat (3) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      for (int c = 0; c < 40; c++) begin
         @(posedge clk);
         #1 if (done) nd++;
      end
      tests++; if (nd !== 0) begin fails++; $display("FAIL midreset_no_done got %0d want 0", nd); end
      run_frame(impulse(), lat, nd);
      tests++;
      if (lat !== 33 || re(3) !== 256 || im(3) !== 0) begin
         fails++; $display("FAIL midreset_recover got lat=%0d x3=(%0d,%0d) want 33 (256,0)", lat, re(3), im(3));
      end
   endtask

   task automatic test_fullscale();
      int lat, nd;
      run_frame(fill({16'h7fff, 16'h8000}), lat, nd);
      for (int n = 0; n < 16; n++) begin
         tests++;
         if (!near(re(n), n == 0 ? 32767 : 0) || !near(im(n), n == 0 ? -32768 : 0)) begin
            fails++; $display("FAIL fullscale_x%0d got (%0d,%0d) want (%0d,%0d)", n, re(n), im(n),
                              n == 0 ? 32767 : 0, n == 0 ? -32768 : 0);
         end
      end
   endtask

   initial begin
      test_reset();
      test_impulse();
      test_constant();
      test_tone();
      test_back_to_back();
      test_reset_mid();
      test_fullscale();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
